// File: rtl/avg_pool_stream.sv
// Streaming 2x2 average pooling over an NxN signed feature map in raster order.
// A half-row buffer of partial sums avoids storing the full map.
module avg_pool_stream #(
    parameter int N  = 28,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);
    localparam int CW  = $clog2(N);
    localparam int HW  = N / 2;
    localparam int LBW = (CW > 1) ? CW - 1 : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [CW-1:0]        row_q, row_d;
    logic signed [DW:0]   pair_q, pair_d;
    logic signed [DW:0]   lbuf_q [HW];
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [DW-1:0]        out_data_q, out_data_d;

    logic                 in_fire;
    logic                 lbuf_we;
    logic                 result_en;
    logic [LBW-1:0]       lbuf_idx;
    logic signed [DW:0]   in_ext;
    logic signed [DW:0]   lbuf_wdata;
    logic signed [DW+1:0] win_sum;
    logic                 unused_sum_lsbs;

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign lbuf_idx = LBW'(col_q >> 1);

    always_comb begin
        in_ext      = $signed({in_data[DW-1], in_data});
        lbuf_wdata  = pair_q + in_ext;
        // Window sum needs two guard bits; dropping the two LSBs is the floor divide by 4.
        win_sum     = $signed({lbuf_q[lbuf_idx][DW], lbuf_q[lbuf_idx]})
                    + $signed({pair_q[DW], pair_q})
                    + $signed({in_ext[DW], in_ext});
        lbuf_we     = in_fire && col_q[0] && !row_q[0];
        result_en   = in_fire && col_q[0] && row_q[0];

        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (in_fire) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                pair_d = in_ext;
            end
        end

        if (result_en) begin
            out_valid_d = 1'b1;
            out_data_d  = win_sum[DW+1:2];
            out_last_d  = (row_q == LAST) && (col_q == LAST);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign unused_sum_lsbs = ^win_sum[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Every entry is written on an even row before it is read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf_q[lbuf_idx] <= lbuf_wdata;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/avg_pool_stream.md
Name: avg_pool_stream

Overview:
Streaming 2x2 average-pooling stage that sits directly downstream of the 5x5 convolution stage. It consumes the convolved feature map one signed 16-bit pixel per handshake in raster order (row 0 col 0 first) and emits the (N/2)x(N/2) pooled map in raster order. A half-row line buffer holds partial sums, so the block never stores the full map.

Parameters:
N, 28, input feature-map width and height (convolution output size for a 32x32 image); must be even and at least 2
DW, 16, pixel width (signed two's complement)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts in_data this cycle
in_data  input  DW  signed convolved pixel, raster order
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_data  output  DW  signed pooled pixel, raster order
out_last  output  1  qualifies the final pooled pixel of a frame (valid with out_valid)

Behaviour:
- Reset is asynchronous and active-low (rst_n); clk is the only clock.
- Reset values: out_valid=0, out_data=0, out_last=0, col=0, row=0, pair register=0. Line-buffer contents are not reset; every entry is written on an even row before it is read.
- Accept: input transfer when in_valid && in_ready. in_ready = !out_valid || out_ready, combinationally. Output transfer when out_valid && out_ready.
- Counters: col 0..N-1 and row 0..N-1 advance only on input transfer. col wraps to 0 and row increments at col=N-1. At row=N-1, col=N-1 both wrap to 0, and the next frame starts with no idle cycle.
- Even column: pair = sign-extended in_data, held in a (DW+1)-bit register.
- Odd column, even row: linebuf[col>>1] = pair + in_data, (DW+1)-bit, no overflow possible.
- Odd column, odd row: sum = linebuf[col>>1] + pair + in_data, (DW+2)-bit. out_data = sum >>> 2 (arithmetic shift, floor toward -inf). The result always fits in DW bits, so no saturation logic is needed. out_valid is set on the next clock edge.
- Latency: out_valid rises 1 cycle after the transfer of the 4th pixel of a 2x2 window.
- out_last = 1 with the pooled pixel produced at row=N-1, col=N-1. It is 0 otherwise.
- Output register holds one entry. Simultaneous output transfer and new result in the same cycle: the register is reloaded and out_valid stays 1.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0. out_data and out_last stay stable until the transfer.
- out_valid clears on an output transfer when no new result is loaded.
- in_valid low for any number of cycles: no state change. Gaps are allowed mid-row and mid-window.
- Reset mid-frame: counters return to 0, any pending output is discarded, and the next accepted pixel is treated as row 0 col 0.
- No internal storage beyond N/2 x (DW+1) line buffer, pair register, output register, counters.

Test Plan:
- N=4, in_data 0..15 in raster order, out_ready=1 -> outputs 2, 4, 10, 12 in order; out_last only on 12; each out_valid rises 1 cycle after pixels 5, 7, 13, 15 are accepted.
- N=4, window {-1,-1,-1,-2} in the top-left with other pixels 0 -> first output -2 (sum -5 floored), not -1.
- All pixels 32767 -> every output 32767. All pixels -32768 -> every output -32768. Checks no overflow at the (DW+2)-bit sum.
- N=4 ramp with out_ready held 0 for 5 cycles after the first result -> in_ready=0 and out_data=2 stable throughout; after release the remaining outputs 4, 10, 12 are unchanged, with no loss or duplication.
- Random in_valid gaps (50%) and random out_ready (50%) over 3 back-to-back N=28 frames -> output matches the reference model bit-exactly; 196 outputs per frame; out_last on every 196th.
- rst_n pulsed low asynchronously mid-row 2 of a frame, then a fresh 0..15 frame (N=4) -> out_valid=0 immediately on assertion; after release the outputs are 2, 4, 10, 12 with no stale data.
